// File: rtl/write_buffer_pkg.sv
// Shared definitions for the write buffer: FSM state encoding.
// Imported by write_buffer (FSM and memory port).
// IDLE=0, WRITE=1 (drain in flight), READ=2 (read miss in flight).
package write_buffer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_READ  = 2'd2
  } wb_state_t;

endpackage

// File: rtl/wb_fifo.sv
// wb_fifo: 2^DEPTH_BITS-entry {addr, data} FIFO with an associative address lookup.
// Ports: enq/deq push tail / pop head; upd overwrites data of entry upd_idx in place;
//   lookup_addr is matched against all valid entries: rd_hit/rd_data report the newest
//   match, wr_hit/wr_idx report a match that may be coalesced (the head is excluded while
//   protect_head=1). head_* and count/full describe the current contents.
// Latency: lookups are combinational; all updates take effect on the next rising clk.
module wb_fifo #(
  parameter int ADDR_WIDTH = 64,
  parameter int WORD_WIDTH = 64,
  parameter int DEPTH_BITS = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enq,
  input  logic [ADDR_WIDTH-1:0] enq_addr,
  input  logic [WORD_WIDTH-1:0] enq_data,
  input  logic                  deq,
  input  logic                  upd,
  input  logic [DEPTH_BITS-1:0] upd_idx,
  input  logic [WORD_WIDTH-1:0] upd_data,
  input  logic [ADDR_WIDTH-1:0] lookup_addr,
  input  logic                  protect_head,
  output logic [DEPTH_BITS-1:0] head_idx,
  output logic [ADDR_WIDTH-1:0] head_addr,
  output logic [WORD_WIDTH-1:0] head_data,
  output logic [DEPTH_BITS:0]   count,
  output logic                  full,
  output logic                  wr_hit,
  output logic [DEPTH_BITS-1:0] wr_idx,
  output logic                  rd_hit,
  output logic [WORD_WIDTH-1:0] rd_data
);

  localparam int N = 1 << DEPTH_BITS;

  logic [ADDR_WIDTH-1:0] addr_q [N];
  logic [WORD_WIDTH-1:0] data_q [N];
  logic [DEPTH_BITS-1:0] head;
  logic [DEPTH_BITS-1:0] tail;
  logic [DEPTH_BITS-1:0] idx;

  // Pointers wrap naturally; count carries the extra bit that separates full from empty.
  always_ff @(posedge clk) begin
    if (rst) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (enq) tail <= tail + 1'b1;
      if (deq) head <= head + 1'b1;
      count <= count + (DEPTH_BITS+1)'(enq) - (DEPTH_BITS+1)'(deq);
    end
  end

  always_ff @(posedge clk) begin
    if (enq) begin
      addr_q[tail] <= enq_addr;
      data_q[tail] <= enq_data;
    end
    if (upd) data_q[upd_idx] <= upd_data;
  end

  // Scan oldest to newest so the last match seen is the newest one. Coalescing keeps at
  // most one unprotected entry per address, so wr_idx is unique.
  always_comb begin
    wr_hit  = 1'b0;
    wr_idx  = '0;
    rd_hit  = 1'b0;
    rd_data = '0;
    idx     = '0;
    for (int o = 0; o < N; o++) begin
      idx = head + DEPTH_BITS'(o);
      if (((DEPTH_BITS+1)'(o) < count) && (addr_q[idx] == lookup_addr)) begin
        rd_hit  = 1'b1;
        rd_data = data_q[idx];
        if (!(protect_head && (o == 0))) begin
          wr_hit = 1'b1;
          wr_idx = idx;
        end
      end
    end
  end

  assign head_idx  = head;
  assign head_addr = addr_q[head];
  assign head_data = data_q[head];
  assign full      = count[DEPTH_BITS];

endmodule

// File: rtl/write_buffer.sv
// write_buffer: posted-write buffer between a cache (addr/din/dout/re/we/ready) and memory
//   (maddr/mout/min/mre/mwe/mready). Writes coalesce or enqueue with zero latency, reads hit
//   the buffer with zero latency, read misses go to memory ahead of pending drains.
// Latency: ready is combinational; a stalled request completes in the memory completion cycle.
// Backpressure: ready=0 for a write into a full buffer or a read miss until memory completes.
module write_buffer
  import write_buffer_pkg::*;
#(
  parameter int ADDR_WIDTH = 64,
  parameter int WORD_WIDTH = 64,
  parameter int DEPTH_BITS = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [WORD_WIDTH-1:0] din,
  output logic [WORD_WIDTH-1:0] dout,
  input  logic                  re,
  input  logic                  we,
  output logic                  ready,
  output logic [ADDR_WIDTH-1:0] maddr,
  output logic [WORD_WIDTH-1:0] mout,
  input  logic [WORD_WIDTH-1:0] min,
  output logic                  mre,
  output logic                  mwe,
  input  logic                  mready
);

  wb_state_t state, state_nxt;

  logic                  enq, deq, upd, launch_rd, launch_wr;
  logic [DEPTH_BITS-1:0] head_idx, wr_idx;
  logic [ADDR_WIDTH-1:0] head_addr;
  logic [WORD_WIDTH-1:0] head_data, rd_data;
  logic [DEPTH_BITS:0]   count;
  logic                  full, wr_hit, rd_hit;
  logic                  rd_miss, mem_done;

  wb_fifo #(
    .ADDR_WIDTH(ADDR_WIDTH),
    .WORD_WIDTH(WORD_WIDTH),
    .DEPTH_BITS(DEPTH_BITS)
  ) u_fifo (
    .clk         (clk),
    .rst         (rst),
    .enq         (enq),
    .enq_addr    (addr),
    .enq_data    (din),
    .deq         (deq),
    .upd         (upd),
    .upd_idx     (wr_idx),
    .upd_data    (din),
    .lookup_addr (addr),
    .protect_head(state == ST_WRITE),
    .head_idx    (head_idx),
    .head_addr   (head_addr),
    .head_data   (head_data),
    .count       (count),
    .full        (full),
    .wr_hit      (wr_hit),
    .wr_idx      (wr_idx),
    .rd_hit      (rd_hit),
    .rd_data     (rd_data)
  );

  // we wins over re, so a read miss only exists when we=0.
  assign rd_miss  = re && !we && !rd_hit;
  // The pulse cycle itself never completes: completion is a later cycle with mready=1.
  assign mem_done = mready && !mre && !mwe;

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    launch_rd = 1'b0;
    launch_wr = 1'b0;
    enq       = 1'b0;
    deq       = 1'b0;
    upd       = 1'b0;
    ready     = 1'b0;
    dout      = '0;

    case (state)
      ST_IDLE: begin
        if (rd_miss) begin
          state_nxt = ST_READ;
          launch_rd = 1'b1;
        end else if (count != '0) begin
          state_nxt = ST_WRITE;
          launch_wr = 1'b1;
        end
      end
      ST_WRITE: begin
        if (mem_done) begin
          state_nxt = ST_IDLE;
          deq       = 1'b1;
        end
      end
      ST_READ: begin
        if (mem_done) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase

    if (we) begin
      if (wr_hit) begin
        upd   = 1'b1;
        ready = 1'b1;
      end else if (!full || deq) begin
        // A full buffer frees its head on the drain-completion edge; reuse that slot.
        enq   = 1'b1;
        ready = 1'b1;
      end
    end else if (re) begin
      if (state == ST_READ) begin
        if (mem_done) begin
          ready = 1'b1;
          dout  = min;
        end
      end else if (rd_hit) begin
        ready = 1'b1;
        dout  = rd_data;
      end
    end

    if (rst) begin
      ready = 1'b0;
      dout  = '0;
    end
  end

  // A write coalescing into the head in the same cycle the drain launches must be
  // forwarded, otherwise the stale head data would go to memory.
  always_ff @(posedge clk) begin
    if (rst) begin
      mre   <= 1'b0;
      mwe   <= 1'b0;
      maddr <= '0;
      mout  <= '0;
    end else begin
      mre <= launch_rd;
      mwe <= launch_wr;
      if (launch_rd) begin
        maddr <= addr;
      end else if (launch_wr) begin
        maddr <= head_addr;
        mout  <= (upd && (wr_idx == head_idx)) ? din : head_data;
      end
    end
  end

endmodule

// File: tb/tb_write_buffer.sv
module tb_write_buffer;

  localparam int LAT = 3;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [63:0] addr = '0, din = '0, min = '0;
  logic        re = 1'b0, we = 1'b0, mready = 1'b0;
  logic [63:0] dout, maddr, mout;
  logic        ready, mre, mwe;

  write_buffer #(.ADDR_WIDTH(64), .WORD_WIDTH(64), .DEPTH_BITS(2)) dut (
    .clk(clk), .rst(rst), .addr(addr), .din(din), .dout(dout), .re(re), .we(we),
    .ready(ready), .maddr(maddr), .mout(mout), .min(min), .mre(mre), .mwe(mwe),
    .mready(mready)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] a;
    logic [63:0] d;
    int          c;
    int          nw;
  } ev_t;

  int n_cmp = 0, n_fail = 0;
  int cyc = 0, last_ready_cyc = 0;
  ev_t mwe_q[$], mre_q[$];
  int  done_q[$];
  logic [63:0] mem_img [logic [63:0]];
  logic [63:0] latest  [logic [63:0]];
  logic hold = 1'b0;
  bit   outst = 1'b0, prev_pulse = 1'b0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  function automatic logic [63:0] init_val(input logic [63:0] a);
    return a ^ 64'h5A5A_0000;
  endfunction

  function automatic logic [63:0] mem_rd(input logic [63:0] a);
    return mem_img.exists(a) ? mem_img[a] : init_val(a);
  endfunction

  // Upstream view: a read must see the last accepted write, else what memory holds.
  function automatic logic [63:0] exp_rd(input logic [63:0] a);
    return latest.exists(a) ? latest[a] : mem_rd(a);
  endfunction

  function automatic logic [63:0] mwe_a(input int i);
    return (i < mwe_q.size()) ? mwe_q[i].a : '1;
  endfunction
  function automatic logic [63:0] mwe_d(input int i);
    return (i < mwe_q.size()) ? mwe_q[i].d : '1;
  endfunction

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Memory: mready rises LAT cycles after a pulse (frozen while hold=1); read data at completion.
  initial begin
    logic p_wr, p_rd, pend_rd;
    logic [63:0] pa, pd, pend_a;
    int cnt;
    cnt = 0; pend_rd = 1'b0; pend_a = '0;
    forever begin
      @(negedge clk);
      p_wr = mwe; p_rd = mre; pa = maddr; pd = mout;
      @(posedge clk);
      #1;
      mready = 1'b0;
      min    = '0;
      if (p_wr || p_rd) begin
        cnt     = LAT - 1;
        pend_rd = p_rd;
        pend_a  = pa;
        if (p_wr) mem_img[pa] = pd;
      end else if (cnt != 0 && !hold) begin
        if (cnt == 1) begin
          mready = 1'b1;
          if (pend_rd) min = mem_rd(pend_a);
        end
        cnt--;
      end
    end
  end

  // Compare process: upstream coherence, idle dout, pulse discipline.
  always @(negedge clk) begin
    if (rst) begin
      chk("ready_in_rst", 64'(ready), 64'd0);
      outst      = 1'b0;
      prev_pulse = 1'b0;
    end else begin
      if (ready && we) latest[addr] = din;
      if (ready && re && !we) chk("read_data", dout, exp_rd(addr));
      else                    chk("dout_idle", dout, 64'd0);
      if (mwe || mre) begin
        chk("pulse_excl", 64'(mwe && mre), 64'd0);
        chk("one_outstanding", 64'(outst), 64'd0);
        chk("pulse_width", 64'(prev_pulse), 64'd0);
        outst = 1'b1;
        if (mwe) mwe_q.push_back('{maddr, mout, cyc, 0});
        if (mre) mre_q.push_back('{maddr, 64'd0, cyc, mwe_q.size()});
      end else if (mready) begin
        outst = 1'b0;
        done_q.push_back(cyc);
      end
      prev_pulse = mwe || mre;
    end
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    repeat (n) @(posedge clk);
    @(negedge clk);
    chk("rst_mwe", 64'(mwe), 64'd0);
    chk("rst_mre", 64'(mre), 64'd0);
    chk("rst_maddr", maddr, 64'd0);
    chk("rst_mout", mout, 64'd0);
    chk("rst_count", 64'(dut.u_fifo.count), 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    hold = 1'b0;
    mwe_q.delete(); mre_q.delete(); done_q.delete();
    latest.delete();
  endtask

  // kind: 0 read, 1 write, 2 read+write (acts as write)
  task automatic xfer(input int kind, input logic [63:0] a, input logic [63:0] d,
                      output int waited, output logic [63:0] rd);
    addr = a; din = d;
    we = (kind != 0); re = (kind != 1);
    waited = 0; rd = '0;
    forever begin
      @(negedge clk);
      if (ready) break;
      waited++;
      if (waited > 200) begin
        chk("xfer_timeout", 64'd1, 64'd0);
        break;
      end
    end
    rd = dout;
    last_ready_cyc = cyc;
    @(posedge clk);
    #1;
    we = 1'b0; re = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int w, gap;
    logic [63:0] r;

    do_reset(LAT + 3);
    // Back-to-back writes drain in order.
    xfer(1, 64'h10, 64'hAA, w, r); chk("t1_wait0", 64'(w), 64'd0);
    xfer(1, 64'h20, 64'hBB, w, r); chk("t1_wait1", 64'(w), 64'd0);
    idle(20);
    chk("t1_nmwe", 64'(mwe_q.size()), 64'd2);
    chk("t1_a0", mwe_a(0), 64'h10); chk("t1_d0", mwe_d(0), 64'hAA);
    chk("t1_a1", mwe_a(1), 64'h20); chk("t1_d1", mwe_d(1), 64'hBB);

    do_reset(LAT + 3);
    // Coalesce before drain: one write to memory carrying the newer data.
    xfer(1, 64'h10, 64'h1, w, r);
    xfer(1, 64'h10, 64'h2, w, r); chk("t2_wait", 64'(w), 64'd0);
    idle(20);
    chk("t2_nmwe", 64'(mwe_q.size()), 64'd1);
    chk("t2_a", mwe_a(0), 64'h10); chk("t2_d", mwe_d(0), 64'h2);

    do_reset(LAT + 3);
    // Full buffer: fifth write stalls until the first drain completes.
    hold = 1'b1;
    for (int i = 0; i < 4; i++) begin
      xfer(1, 64'h10 * 64'(i + 1), 64'hA0 + 64'(i), w, r);
      chk("t3_fill_wait", 64'(w), 64'd0);
    end
    fork
      xfer(1, 64'h50, 64'h55, w, r);
      begin repeat (6) @(posedge clk); #1; hold = 1'b0; end
    join
    chk("t3_stalled", 64'(w >= 5), 64'd1);
    chk("t3_ready_at_done", 64'(last_ready_cyc), 64'(done_q.size() > 0 ? done_q[0] : -1));
    chk("t3_count", 64'(dut.u_fifo.count), 64'd4);
    idle(40);
    chk("t3_nmwe", 64'(mwe_q.size()), 64'd5);
    for (int i = 0; i < 5; i++) chk("t3_order", mwe_a(i), 64'h10 * 64'(i + 1));

    do_reset(LAT + 3);
    // Read hit returns buffered data at once; later miss returns it from memory.
    xfer(1, 64'h30, 64'h77, w, r);
    xfer(0, 64'h30, 64'h0, w, r);
    chk("t4_hit_wait", 64'(w), 64'd0); chk("t4_hit_data", r, 64'h77);
    idle(20);
    chk("t4_no_mre", 64'(mre_q.size()), 64'd0);
    xfer(0, 64'h30, 64'h0, w, r);
    chk("t4_miss_wait", 64'(w), 64'd4); chk("t4_miss_data", r, 64'h77);
    chk("t4_one_mre", 64'(mre_q.size()), 64'd1);

    do_reset(LAT + 3);
    // Read miss during a drain goes ahead of the remaining queued write.
    xfer(1, 64'h40, 64'h44, w, r);
    xfer(1, 64'h41, 64'h45, w, r);
    xfer(0, 64'h90, 64'h0, w, r);
    chk("t5_data", r, 64'h5A5A_0090);
    chk("t5_nmre", 64'(mre_q.size()), 64'd1);
    chk("t5_maddr", (mre_q.size() > 0) ? mre_q[0].a : '1, 64'h90);
    chk("t5_mwe_before", 64'((mre_q.size() > 0) ? mre_q[0].nw : -1), 64'd1);
    gap = (mre_q.size() > 0 && done_q.size() > 0) ? mre_q[0].c - done_q[0] : -1;
    chk("t5_issue_gap", 64'(gap >= 1 && gap <= 2), 64'd1);
    chk("t5_ready_at_done", 64'(last_ready_cyc), 64'(done_q.size() > 1 ? done_q[1] : -1));
    idle(20);
    chk("t5_nmwe", 64'(mwe_q.size()), 64'd2);
    chk("t5_a1", mwe_a(1), 64'h41);

    do_reset(LAT + 3);
    // Reset in the middle of a drain with three entries queued behind it.
    for (int i = 0; i < 4; i++) xfer(1, 64'h60 + 64'(i), 64'hC0 + 64'(i), w, r);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    latest.delete();
    @(negedge clk);
    chk("t6_mwe", 64'(mwe), 64'd0);
    chk("t6_count", 64'(dut.u_fifo.count), 64'd0);
    idle(30);
    chk("t6_nmwe", 64'(mwe_q.size()), 64'd1);
    chk("t6_nmre", 64'(mre_q.size()), 64'd0);
    xfer(1, 64'h70, 64'h7, w, r);
    idle(20);
    chk("t6_after_nmwe", 64'(mwe_q.size()), 64'd2);
    chk("t6_after_a", mwe_a(1), 64'h70);

    do_reset(LAT + 3);
    // re+we acts as a write; mixed traffic through a buffer that overflows.
    xfer(1, 64'h102, 64'h11, w, r);
    xfer(2, 64'h102, 64'h22, w, r); chk("t7_both_wait", 64'(w), 64'd0);
    xfer(0, 64'h102, 64'h0, w, r);  chk("t7_both_data", r, 64'h22);
    for (int i = 0; i < 8; i++) begin
      xfer(1, 64'h100 + 64'(i), 64'(i * 3 + 1), w, r);
      if (i % 2 == 1) xfer(0, 64'h100 + 64'(i / 2), 64'h0, w, r);
    end
    idle(60);
    xfer(0, 64'h102, 64'h0, w, r); chk("t7_r102", r, 64'h7);
    xfer(0, 64'h105, 64'h0, w, r); chk("t7_r105", r, 64'h10);
    xfer(0, 64'h1FF, 64'h0, w, r); chk("t7_r1ff", r, 64'h5A5A_01FF);
    idle(5);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
